spi_master: RTL and testbench

- Single-frame SPI master that drives the serial side of our SPI slave (SCL, CS_n, MOSI) and captures MISO.
- Converts a parallel start/tx_data request on the system clock into one 8-bit full-duplex frame.
- SCL is generated by dividing clk.
- Returns the received byte with a one-cycle done pulse.

---
 rtl/spi_master.sv | 139 +++++++++++++
 tb/tb_spi_master.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: single-frame, 8-bit, full-duplex SPI master.
// A start request in IDLE produces one CS_n-framed transfer of 16 SCL edges.
// The received byte is returned on rx_data together with a one-cycle done pulse.
// SCL is derived from clk by a half-period divider of CLK_DIV cycles.
module spi_master #(
  parameter bit          CPOL    = 1'b0,
  parameter bit          CPHA    = 1'b0,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       SCL,
  output logic       CS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state;
  logic [7:0] div_cnt;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic [4:0] edge_cnt;
  logic       tick;
  logic       leading;

  // End of one SCL half-period.
  assign tick    = (div_cnt == DIV_LAST);
  // edge_cnt counts completed edges, so the next edge is odd (leading) when it is even.
  assign leading = ~edge_cnt[0];

  // Frame sequencer with all serial-side and handshake outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      edge_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      SCL      <= CPOL;
      CS_n     <= 1'b1;
      MOSI     <= 1'b0;
    end else begin
      done <= 1'b0;
      // Every non-IDLE state change happens on a tick, so the wrap to zero
      // doubles as the clear-on-entry of the divider.
      div_cnt <= tick ? '0 : div_cnt + 8'd1;

      case (state)
        IDLE: begin
          div_cnt <= '0;
          CS_n    <= 1'b1;
          SCL     <= CPOL;
          busy    <= 1'b0;
          MOSI    <= 1'b0;
          if (start) begin
            tx_shift <= tx_data;
            rx_shift <= '0;
            edge_cnt <= '0;
            CS_n     <= 1'b0;
            busy     <= 1'b1;
            MOSI     <= CPHA ? 1'b0 : tx_data[7];
            state    <= SETUP;
          end
        end

        SETUP: begin
          if (tick) begin
            state <= XFER;
          end
        end

        XFER: begin
          if (tick) begin
            SCL      <= ~SCL;
            edge_cnt <= edge_cnt + 5'd1;
            if (leading) begin
              if (CPHA) begin
                MOSI     <= tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
              end else begin
                rx_shift <= {rx_shift[6:0], MISO};
              end
            end else begin
              if (CPHA) begin
                rx_shift <= {rx_shift[6:0], MISO};
              end else if (edge_cnt != 5'd15) begin
                MOSI     <= tx_shift[6];
                tx_shift <= {tx_shift[6:0], 1'b0};
              end
            end
            if (edge_cnt == 5'd15) begin
              state <= HOLD;
            end
          end
        end

        HOLD: begin
          if (tick) begin
            CS_n    <= 1'b1;
            MOSI    <= 1'b0;
            rx_data <= rx_shift;
            done    <= 1'b1;
            state   <= GAP;
          end
        end

        GAP: begin
          if (tick) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed self-checking bench for spi_master.
// Four instances cover SPI modes 0..3; a clocked slave model answers on MISO,
// records the MOSI stream and counts CS_n-low cycles, SCL toggles and done pulses.
module tb_spi_master;

  localparam bit CPOL_T [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam bit CPHA_T [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  localparam int DIV_T  [4] = '{2, 4, 1, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic       start [4];
  logic [7:0] txd   [4];
  logic       busy  [4];
  logic       done  [4];
  logic [7:0] rxd   [4];
  logic       scl   [4];
  logic       cs_n  [4];
  logic       mosi  [4];
  logic       miso  [4];

  // slave model state
  logic [7:0] sl_tx  [4] = '{default: 8'h00};
  logic [7:0] sl_rx  [4] = '{default: 8'h00};
  logic       sl_out [4] = '{default: 1'b0};
  bit         loopb  [4] = '{default: 1'b0};
  int         sl_bit [4] = '{default: 0};

  // monitor counters
  int cs_low   [4] = '{default: 0};
  int toggles  [4] = '{default: 0};
  int done_cnt [4] = '{default: 0};
  int bad_mosi [4] = '{default: 0};
  int cs_falls [4] = '{default: 0};
  logic prev_scl  [4];
  logic prev_mosi [4];
  logic prev_cs   [4] = '{default: 1'b1};

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_master #(
      .CPOL   (CPOL_T[g]),
      .CPHA   (CPHA_T[g]),
      .CLK_DIV(DIV_T[g])
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start[g]),
      .tx_data(txd[g]),
      .busy   (busy[g]),
      .done   (done[g]),
      .rx_data(rxd[g]),
      .SCL    (scl[g]),
      .CS_n   (cs_n[g]),
      .MOSI   (mosi[g]),
      .MISO   (miso[g])
    );
    assign miso[g] = loopb[g] ? mosi[g] : sl_out[g];
  end

  // Slave model and protocol monitor, evaluated half a cycle after each DUT update.
  always @(negedge clk) begin
    bit lead;
    for (int d = 0; d < 4; d++) begin
      if (cs_n[d] === 1'b0) cs_low[d]++;
      if (done[d] === 1'b1) done_cnt[d]++;
      if (prev_cs[d] === 1'b1 && cs_n[d] === 1'b0) begin
        cs_falls[d]++;
        sl_bit[d] = 0;
        sl_rx[d]  = 8'h00;
        sl_out[d] = CPHA_T[d] ? 1'b0 : sl_tx[d][7];
      end else if (cs_n[d] === 1'b0 && scl[d] !== prev_scl[d]) begin
        toggles[d]++;
        lead = (scl[d] != CPOL_T[d]);
        if (lead == !CPHA_T[d]) begin
          sl_rx[d] = {sl_rx[d][6:0], mosi[d]};
          if (mosi[d] !== prev_mosi[d]) bad_mosi[d]++;
        end
        if (!CPHA_T[d] && !lead) begin
          sl_bit[d]++;
          if (sl_bit[d] < 8) sl_out[d] = sl_tx[d][7 - sl_bit[d]];
        end
        if (CPHA_T[d] && lead && sl_bit[d] < 8) sl_out[d] = sl_tx[d][7 - sl_bit[d]];
        if (CPHA_T[d] && !lead) sl_bit[d]++;
      end else if (cs_n[d] === 1'b0 && prev_cs[d] === 1'b0 && mosi[d] !== prev_mosi[d]) begin
        bad_mosi[d]++;
      end
      prev_scl[d]  = scl[d];
      prev_mosi[d] = mosi[d];
      prev_cs[d]   = cs_n[d];
    end
  end

  // One complete frame on instance d with its own inline checks.
  task automatic test_frame(input int d, input logic [7:0] tx, input logic [7:0] sb,
                            input bit lb, input string nm);
    int cyc, w, b_low, b_tog, b_done, b_bad;
    logic [7:0] exp_rx;
    exp_rx = lb ? tx : sb;
    @(negedge clk);
    sl_tx[d] = sb;
    loopb[d] = lb;
    b_low  = cs_low[d];
    b_tog  = toggles[d];
    b_done = done_cnt[d];
    b_bad  = bad_mosi[d];
    start[d] = 1'b1;
    txd[d]   = tx;
    @(negedge clk);
    start[d] = 1'b0;
    txd[d]   = ~tx;
    cyc = 1;
    checks++;
    if (busy[d] !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_after_start: got %b expected 1", nm, busy[d]);
    end
    while (done[d] !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== 18 * DIV_T[d] + 1) begin
      failures++;
      $display("FAIL %s start_to_done: got %0d expected %0d", nm, cyc, 18 * DIV_T[d] + 1);
    end
    checks++;
    if (rxd[d] !== exp_rx) begin
      failures++;
      $display("FAIL %s rx_data: got %h expected %h", nm, rxd[d], exp_rx);
    end
    checks++;
    if (sl_rx[d] !== tx) begin
      failures++;
      $display("FAIL %s mosi_stream: got %h expected %h", nm, sl_rx[d], tx);
    end
    checks++;
    if (cs_n[d] !== 1'b1) begin
      failures++;
      $display("FAIL %s cs_n_at_done: got %b expected 1", nm, cs_n[d]);
    end
    w = 0;
    while (busy[d] !== 1'b0 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w !== DIV_T[d]) begin
      failures++;
      $display("FAIL %s done_to_idle: got %0d expected %0d", nm, w, DIV_T[d]);
    end
    checks++;
    if (cs_low[d] - b_low !== 18 * DIV_T[d]) begin
      failures++;
      $display("FAIL %s cs_low_cycles: got %0d expected %0d", nm, cs_low[d] - b_low, 18 * DIV_T[d]);
    end
    checks++;
    if (toggles[d] - b_tog !== 16) begin
      failures++;
      $display("FAIL %s scl_toggles: got %0d expected 16", nm, toggles[d] - b_tog);
    end
    checks++;
    if (done_cnt[d] - b_done !== 1) begin
      failures++;
      $display("FAIL %s done_pulses: got %0d expected 1", nm, done_cnt[d] - b_done);
    end
    checks++;
    if (bad_mosi[d] - b_bad !== 0) begin
      failures++;
      $display("FAIL %s mosi_edge: got %0d wrong-edge changes expected 0", nm, bad_mosi[d] - b_bad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (cs_n[d] !== 1'b1 || scl[d] !== CPOL_T[d] || mosi[d] !== 1'b0 ||
          busy[d] !== 1'b0 || done[d] !== 1'b0 || rxd[d] !== 8'h00) begin
        failures++;
        $display("FAIL reset_state[%0d]: got cs_n=%b scl=%b mosi=%b busy=%b done=%b rx=%h expected cs_n=1 scl=%b mosi=0 busy=0 done=0 rx=00",
                 d, cs_n[d], scl[d], mosi[d], busy[d], done[d], rxd[d], CPOL_T[d]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mode0();
    test_frame(0, 8'hA5, 8'h3C, 1'b0, "mode0");
  endtask

  task automatic test_mode3();
    checks++;
    if (scl[1] !== 1'b1) begin
      failures++;
      $display("FAIL mode3 scl_idle: got %b expected 1", scl[1]);
    end
    test_frame(1, 8'h81, 8'hFE, 1'b0, "mode3");
  endtask

  task automatic test_loopback_div1();
    test_frame(2, 8'h5A, 8'h00, 1'b1, "mode1_loop");
    test_frame(3, 8'h5A, 8'h00, 1'b1, "mode2_loop");
  endtask

  task automatic test_back_to_back();
    int n, hi, b_fall, b_done;
    b_fall = cs_falls[0];
    b_done = done_cnt[0];
    @(negedge clk);
    sl_tx[0] = 8'h3C;
    loopb[0] = 1'b0;
    start[0] = 1'b1;
    txd[0]   = 8'h11;
    @(negedge clk);
    txd[0] = 8'h22;
    n = 0;
    while (done[0] !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sl_rx[0] !== 8'h11 || rxd[0] !== 8'h3C) begin
      failures++;
      $display("FAIL b2b_first: got mosi=%h rx=%h expected mosi=11 rx=3c", sl_rx[0], rxd[0]);
    end
    sl_tx[0] = 8'hE7;
    // CS_n stays high through GAP plus the IDLE cycle that accepts the held start.
    hi = 0;
    while (cs_n[0] === 1'b1 && hi < 100) begin
      @(negedge clk);
      hi++;
    end
    start[0] = 1'b0;
    checks++;
    if (hi !== DIV_T[0] + 1) begin
      failures++;
      $display("FAIL b2b_cs_high_gap: got %0d expected %0d", hi, DIV_T[0] + 1);
    end
    n = 0;
    while (done[0] !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sl_rx[0] !== 8'h22 || rxd[0] !== 8'hE7) begin
      failures++;
      $display("FAIL b2b_second: got mosi=%h rx=%h expected mosi=22 rx=e7", sl_rx[0], rxd[0]);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (cs_falls[0] - b_fall !== 2 || done_cnt[0] - b_done !== 2) begin
      failures++;
      $display("FAIL b2b_frame_count: got frames=%0d dones=%0d expected 2 and 2",
               cs_falls[0] - b_fall, done_cnt[0] - b_done);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n, b_tog, b_done;
    @(negedge clk);
    sl_tx[0] = 8'h3C;
    loopb[0] = 1'b0;
    b_tog    = toggles[0];
    start[0] = 1'b1;
    txd[0]   = 8'hC3;
    @(negedge clk);
    start[0] = 1'b0;
    n = 0;
    while (toggles[0] - b_tog < 7 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (toggles[0] - b_tog !== 7) begin
      failures++;
      $display("FAIL midrst_reach_edge7: got %0d toggles expected 7", toggles[0] - b_tog);
    end
    b_done = done_cnt[0];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (cs_n[0] !== 1'b1 || scl[0] !== 1'b0 || busy[0] !== 1'b0 || rxd[0] !== 8'h00) begin
      failures++;
      $display("FAIL midrst_state: got cs_n=%b scl=%b busy=%b rx=%h expected cs_n=1 scl=0 busy=0 rx=00",
               cs_n[0], scl[0], busy[0], rxd[0]);
    end
    repeat (100) @(negedge clk);
    checks++;
    if (done_cnt[0] - b_done !== 0 || rxd[0] !== 8'h00) begin
      failures++;
      $display("FAIL midrst_no_done: got dones=%0d rx=%h expected 0 and 00", done_cnt[0] - b_done, rxd[0]);
    end
    test_frame(0, 8'h0F, 8'h96, 1'b0, "after_rst");
  endtask

  task automatic test_rst_and_start();
    int b_fall;
    b_fall = cs_falls[0];
    @(negedge clk);
    rst      = 1'b1;
    start[0] = 1'b1;
    txd[0]   = 8'hFF;
    @(negedge clk);
    rst      = 1'b0;
    start[0] = 1'b0;
    checks++;
    if (cs_n[0] !== 1'b1 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL rst_start_same_cycle: got cs_n=%b busy=%b expected 1 and 0", cs_n[0], busy[0]);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (cs_falls[0] - b_fall !== 0 || cs_n[0] !== 1'b1) begin
      failures++;
      $display("FAIL rst_start_no_frame: got frames=%0d cs_n=%b expected 0 and 1",
               cs_falls[0] - b_fall, cs_n[0]);
    end
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      start[d] = 1'b0;
      txd[d]   = 8'h00;
    end
    test_reset();
    test_mode0();
    test_mode3();
    test_loopback_div1();
    test_back_to_back();
    test_reset_mid_frame();
    test_rst_and_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
